// File: rtl/fifo_apb_adc_mc.sv
// Multi-channel ADC sample FIFO feeding the APB register block.
// Shared circular buffer of tagged samples with first-word-fall-through
// read-out. Per-channel accept mask, watermark with a latched
// interrupt, sticky overflow and a saturating drop counter.
`timescale 1ns/1ps
module fifo_apb_adc_mc #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int NUM_CH     = 4,
    parameter int DROP_W     = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adc_wr_en,
    input  logic [CH_W-1:0]       adc_ch,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic                  apb_rd_en,
    output logic [DATA_WIDTH-1:0] apb_rd_data,
    output logic [CH_W-1:0]       apb_rd_ch,
    input  logic                  fifo_clear,
    input  logic [AW:0]           wm_level,
    input  logic                  irq_clr,
    input  logic                  ovf_clr,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [AW:0]           fifo_level,
    output logic                  fifo_wm,
    output logic                  fifo_irq,
    output logic                  fifo_ovf,
    output logic [DROP_W-1:0]     drop_cnt
);

    localparam int          NUM_TAGS = 1 << CH_W;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    // Storage: channel tag in the upper bits, sample below.
    logic [CH_W+DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              wm_q, wm_d;
    logic              irq_q, irq_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // Channel mask widened to every encodable tag; tags beyond NUM_CH
    // read as disabled so an out-of-range channel is silently discarded.
    logic [NUM_TAGS-1:0] ch_en_ext;

    for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_ch_mask
        if (gi < NUM_CH) begin : g_real
            assign ch_en_ext[gi] = ch_enable[gi];
        end else begin : g_unused
            assign ch_en_ext[gi] = 1'b0;
        end
    end

    logic wr_valid;
    logic wr_accept;
    logic rd_accept;
    logic wr_drop;
    logic wm_now;
    logic irq_set;

    // Accept decisions use the count at the start of the cycle only, so a
    // simultaneous pop never makes room for a write when the FIFO is full.
    always_comb begin
        wr_valid  = adc_wr_en && ch_en_ext[adc_ch];
        wr_accept = wr_valid && (count_q != FULL_LVL);
        wr_drop   = wr_valid && (count_q == FULL_LVL);
        rd_accept = apb_rd_en && (count_q != '0);
        wm_now    = (wm_level != '0) && (count_q >= wm_level);
        irq_set   = wm_now && !wm_q;
    end

    // Pointer and occupancy update; a clear overrides any write or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (wr_accept && !rd_accept) begin
                count_d = count_q + (AW+1)'(1);
            end else if (rd_accept && !wr_accept) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // Status flags: set beats clear for both the interrupt and overflow,
    // and a drop coinciding with ovf_clr restarts the counter at one.
    always_comb begin
        wm_d       = wm_now;
        irq_d      = irq_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (wr_drop) begin
            ovf_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wm_q       <= 1'b0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wm_q       <= wm_d;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Sample storage; contents are not reset, and writes are suppressed
    // during reset and clear so a flushed FIFO holds no new data.
    always_ff @(posedge clk) begin
        if (wr_accept && !fifo_clear && !rst) begin
            mem_q[wr_ptr_q] <= {adc_ch, adc_data};
        end
    end

    // Head of queue is shown combinationally for fall-through reads.
    assign {apb_rd_ch, apb_rd_data} = mem_q[rd_ptr_q];

    assign fifo_full  = (count_q == FULL_LVL);
    assign fifo_empty = (count_q == '0);
    assign fifo_level = count_q;
    assign fifo_wm    = wm_now;
    assign fifo_irq   = irq_q;
    assign fifo_ovf   = ovf_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fifo_apb_adc_mc.sv
// Directed self-checking bench for fifo_apb_adc_mc (default parameters).
`timescale 1ns/1ps
module tb_fifo_apb_adc_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_wr_en;
    logic [1:0]  adc_ch;
    logic [63:0] adc_data;
    logic [3:0]  ch_enable;
    logic        apb_rd_en;
    logic [63:0] apb_rd_data;
    logic [1:0]  apb_rd_ch;
    logic        fifo_clear;
    logic [4:0]  wm_level;
    logic        irq_clr;
    logic        ovf_clr;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_level;
    logic        fifo_wm;
    logic        fifo_irq;
    logic        fifo_ovf;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    fifo_apb_adc_mc dut (
        .clk(clk), .rst(rst),
        .adc_wr_en(adc_wr_en), .adc_ch(adc_ch), .adc_data(adc_data),
        .ch_enable(ch_enable), .apb_rd_en(apb_rd_en),
        .apb_rd_data(apb_rd_data), .apb_rd_ch(apb_rd_ch),
        .fifo_clear(fifo_clear), .wm_level(wm_level),
        .irq_clr(irq_clr), .ovf_clr(ovf_clr),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_level(fifo_level), .fifo_wm(fifo_wm),
        .fifo_irq(fifo_irq), .fifo_ovf(fifo_ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [63:0] d);
        adc_wr_en = 1'b1; adc_ch = ch; adc_data = d;
        tick();
        adc_wr_en = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [63:0] d, input logic [1:0] ch);
        check_val({tag, "_data"}, apb_rd_data, d);
        check_val({tag, "_ch"}, {62'd0, apb_rd_ch}, {62'd0, ch});
        apb_rd_en = 1'b1;
        tick();
        apb_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; adc_wr_en = 1'b0; adc_ch = '0; adc_data = '0;
        ch_enable = 4'hF; apb_rd_en = 1'b0; fifo_clear = 1'b0;
        wm_level = '0; irq_clr = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_val("rst_empty", fifo_empty, 1);
        check_val("rst_full", fifo_full, 0);
        check_val("rst_level", fifo_level, 0);
        check_val("rst_wm", fifo_wm, 0);
        check_val("rst_irq", fifo_irq, 0);
        check_val("rst_ovf", fifo_ovf, 0);
        check_val("rst_drop", drop_cnt, 0);

        // Fill to full, then overflow by three.
        for (int i = 0; i < 16; i++) push(2'(i % 4), 64'h100 + 64'(i));
        check_val("fill_full", fifo_full, 1);
        check_val("fill_level", fifo_level, 16);
        for (int i = 0; i < 3; i++) push(2'd1, 64'hDEAD);
        check_val("ovf_flag", fifo_ovf, 1);
        check_val("ovf_drop", drop_cnt, 3);
        check_val("ovf_level", fifo_level, 16);
        check_val("ovf_head", apb_rd_data, 64'h100);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check_val("ovfclr_flag", fifo_ovf, 0);
        check_val("ovfclr_drop", drop_cnt, 0);
        for (int i = 0; i < 16; i++) pop_expect($sformatf("drain%0d", i), 64'h100 + 64'(i), 2'(i % 4));
        check_val("drain_empty", fifo_empty, 1);

        // Wrap rounds: shift the pointers by 5 each round, then fill/drain.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) push(2'(k % 4), 64'h200 + 64'(r * 16 + k));
            for (int k = 0; k < 5; k++) pop_expect($sformatf("off%0d_%0d", r, k), 64'h200 + 64'(r * 16 + k), 2'(k % 4));
            for (int i = 0; i < 16; i++) push(2'(i % 4), 64'h1000 * 64'(r + 1) + 64'(i));
            check_val($sformatf("wrap%0d_full", r), fifo_full, 1);
            for (int i = 0; i < 16; i++) pop_expect($sformatf("wrap%0d_%0d", r, i), 64'h1000 * 64'(r + 1) + 64'(i), 2'(i % 4));
            check_val($sformatf("wrap%0d_empty", r), fifo_empty, 1);
        end

        // Drop counter saturation.
        for (int i = 0; i < 16; i++) push(2'd0, 64'h500 + 64'(i));
        adc_wr_en = 1'b1; adc_ch = 2'd3; adc_data = 64'hBAD;
        repeat (300) tick();
        adc_wr_en = 1'b0;
        check_val("sat_drop", drop_cnt, 255);
        check_val("sat_ovf", fifo_ovf, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check_val("sat_clr_drop", drop_cnt, 0);

        // Write+pop at full: pop wins, write dropped.
        adc_wr_en = 1'b1; apb_rd_en = 1'b1; adc_ch = 2'd2; adc_data = 64'h777;
        tick();
        adc_wr_en = 1'b0; apb_rd_en = 1'b0;
        check_val("fullwp_level", fifo_level, 15);
        check_val("fullwp_drop", drop_cnt, 1);
        check_val("fullwp_ovf", fifo_ovf, 1);
        check_val("fullwp_head", apb_rd_data, 64'h501);

        // Clear overrides write+pop; overflow state kept.
        fifo_clear = 1'b1; adc_wr_en = 1'b1; apb_rd_en = 1'b1;
        tick();
        fifo_clear = 1'b0; adc_wr_en = 1'b0; apb_rd_en = 1'b0;
        check_val("clr_level", fifo_level, 0);
        check_val("clr_empty", fifo_empty, 1);
        check_val("clr_ovf", fifo_ovf, 1);
        check_val("clr_drop", drop_cnt, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

        // Channel mask 0101.
        ch_enable = 4'b0101;
        for (int c = 0; c < 4; c++) push(2'(c), 64'h300 + 64'(c));
        check_val("mask_level", fifo_level, 2);
        check_val("mask_ovf", fifo_ovf, 0);
        pop_expect("mask0", 64'h300, 2'd0);
        pop_expect("mask1", 64'h302, 2'd2);
        ch_enable = 4'hF;

        // Write+pop at level 7.
        for (int i = 0; i < 7; i++) push(2'(i % 4), 64'h400 + 64'(i));
        check_val("wp7_head0", apb_rd_data, 64'h400);
        adc_wr_en = 1'b1; apb_rd_en = 1'b1; adc_ch = 2'd3; adc_data = 64'h4FF;
        tick();
        adc_wr_en = 1'b0; apb_rd_en = 1'b0;
        check_val("wp7_level", fifo_level, 7);
        check_val("wp7_head1", apb_rd_data, 64'h401);
        fifo_clear = 1'b1; tick(); fifo_clear = 1'b0;

        // Watermark and interrupt.
        wm_level = 5'd4;
        for (int i = 0; i < 3; i++) push(2'd0, 64'h600 + 64'(i));
        check_val("wm_below", fifo_wm, 0);
        push(2'd1, 64'h603);
        check_val("wm_at", fifo_wm, 1);
        check_val("irq_pending", fifo_irq, 0);
        tick();
        check_val("irq_set", fifo_irq, 1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check_val("irq_cleared", fifo_irq, 0);
        pop_expect("wm_pop", 64'h600, 2'd0);
        check_val("wm_drop_below", fifo_wm, 0);
        push(2'd2, 64'h604);
        check_val("wm_reedge", fifo_wm, 1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check_val("irq_set_wins", fifo_irq, 1);
        wm_level = 5'd0;
        #1;
        check_val("wm_disabled", fifo_wm, 0);
        for (int i = 0; i < 12; i++) push(2'd3, 64'h700 + 64'(i));
        check_val("wm_dis_full", fifo_wm, 0);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check_val("irq_clr2", fifo_irq, 0);

        // Reset mid-traffic with overflow pending.
        adc_wr_en = 1'b1; adc_ch = 2'd0; adc_data = 64'h999;
        tick();
        check_val("pre_rst_ovf", fifo_ovf, 1);
        rst = 1'b1; apb_rd_en = 1'b1;
        tick(); tick();
        rst = 1'b0; adc_wr_en = 1'b0; apb_rd_en = 1'b0;
        check_val("rst2_empty", fifo_empty, 1);
        check_val("rst2_level", fifo_level, 0);
        check_val("rst2_irq", fifo_irq, 0);
        check_val("rst2_ovf", fifo_ovf, 0);
        check_val("rst2_drop", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_apb_adc_mc.md
# fifo_apb_adc_mc

Multi-channel successor to the single-stream ADC-to-APB sample FIFO. It buffers tagged samples from up to `NUM_CH` ADC channels in one shared circular buffer, and exposes first-word-fall-through read data with its channel tag to the APB register block. It adds per-channel write enables, a programmable watermark with a latched interrupt, a sticky overflow flag with a saturating drop counter, and a level output. It sits between the ADC sequencer and the APB slave register file.

## Interface
- `DATA_WIDTH`, 64, sample width in bits.
- `DEPTH`, 16, entry count; power of two, ≥ 2.
- `NUM_CH`, 4, number of ADC channels; ≥ 1. `CH_W = max(1, $clog2(NUM_CH))`; `AW = $clog2(DEPTH)`.
- `DROP_W`, 8, width of the dropped-sample counter.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `adc_wr_en`  in  1  write strobe from the ADC sequencer.
- `adc_ch`  in  CH_W  channel tag of the write.
- `adc_data`  in  DATA_WIDTH  sample.
- `ch_enable`  in  NUM_CH  per-channel accept mask.
- `apb_rd_en`  in  1  pop strobe.
- `apb_rd_data`  out  DATA_WIDTH  head sample (FWFT).
- `apb_rd_ch`  out  CH_W  head channel tag.
- `fifo_clear`  in  1  synchronous flush.
- `wm_level`  in  AW+1  watermark threshold; 0 disables it.
- `irq_clr`  in  1  clears `fifo_irq`.
- `ovf_clr`  in  1  clears `fifo_ovf` and `drop_cnt`.
- `fifo_full`  out  1  count == DEPTH.
- `fifo_empty`  out  1  count == 0.
- `fifo_level`  out  AW+1  current count.
- `fifo_wm`  out  1  `wm_level != 0 && count >= wm_level`.
- `fifo_irq`  out  1  latched watermark interrupt.
- `fifo_ovf`  out  1  sticky overflow.
- `drop_cnt`  out  DROP_W  saturating count of samples dropped because the FIFO was full.

## Operation
- Storage is DEPTH × (CH_W + DATA_WIDTH). `wr_ptr` and `rd_ptr` are AW bits and wrap naturally at DEPTH-1 → 0. `count` is AW+1 bits.
- The write is valid when `adc_wr_en && ch_enable[adc_ch]`.
  - `adc_ch >= NUM_CH` is treated as disabled.
  - Writes from disabled channels are discarded silently: no count change, no overflow.
- A write is accepted iff it is valid and `count < DEPTH` at the start of the cycle. This holds even if a pop happens in the same cycle; there is no write-through at full.
- A valid write that is not accepted sets `fifo_ovf` and increments `drop_cnt`, which saturates at all-ones. The sample is lost. No entry is overwritten.
- A pop is accepted iff `apb_rd_en && count != 0`. A pop when empty is ignored: no pointer or count change.
- Count update:
  - accepted write only: +1.
  - accepted pop only: −1.
  - both: unchanged, and both pointers advance.
  - Count must never wrap.
- `apb_rd_data`/`apb_rd_ch` show mem[rd_ptr] combinationally. The value is undefined-but-stable when empty; the bench must not check it then.
- `fifo_clear` zeroes `wr_ptr`, `rd_ptr` and `count`, and overrides any write or pop in the same cycle. It does not touch `fifo_ovf`, `drop_cnt` or `fifo_irq`.
- Interrupt:
  - `fifo_irq` sets on the cycle after `fifo_wm` goes 0→1 (registered edge detect of `fifo_wm`).
  - `irq_clr` clears it. If a set and a clear occur in the same cycle, the set wins.
- Overflow: if `ovf_clr` and a new drop occur in the same cycle, `fifo_ovf` = 1 and `drop_cnt` = 1.
- Reset: pointers, count, `fifo_irq`, `fifo_ovf`, `drop_cnt` and the `fifo_wm` edge register are all 0.
  - After reset, outputs are: `fifo_empty`=1, `fifo_full`=0, `fifo_level`=0, `fifo_wm`=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored samples.

## Timing
- Write latency: a sample accepted at edge N is visible on `apb_rd_data` and counted in `fifo_level` after edge N (same-cycle combinational view from N+1).
- Pop: the next head appears immediately after the popping edge.
- `fifo_full`, `fifo_empty`, `fifo_level` and `fifo_wm` are combinational from `count` (and `wm_level` for `fifo_wm`).
- `fifo_irq`, `fifo_ovf` and `drop_cnt` are registered, with one cycle of latency from the causing event.
- Throughput: one write plus one pop per cycle sustained.

## Test plan
- **Reset/defaults:** assert `rst` for 2 cycles mid-traffic → `fifo_empty`=1, `fifo_level`=0, `fifo_irq`=`fifo_ovf`=0, `drop_cnt`=0.
- **Fill/drain ordering:** with `ch_enable`=4'b1111, write 16 samples 0x100+i on channel i%4.
  - `fifo_full`=1, `fifo_level`=16.
  - 16 pops return 0x100..0x10F with tags 0,1,2,3,… in order; then `fifo_empty`=1.
  - Pointer wrap: repeat 3 rounds with an offset of 5 entries; order must be preserved across the wrap.
- **Overflow:** at full, issue 3 more valid writes → `fifo_ovf`=1, `drop_cnt`=3, `fifo_level`=16, and the head is still the first sample. Pulse `ovf_clr` → both return to 0. Then force 300 drops with DROP_W=8 → `drop_cnt`=255.
- **Channel mask:** `ch_enable`=4'b0101, write one sample on each channel 0–3 → `fifo_level`=2, tags 0 and 2 only, `fifo_ovf`=0.
- **Watermark/IRQ:** `wm_level`=4.
  - Write 4 → `fifo_wm`=1, and `fifo_irq`=1 one cycle later.
  - `irq_clr` on the same cycle as a fresh 0→1 edge → `fifo_irq` stays 1.
  - `wm_level`=0 → `fifo_wm`=0 at any level.
- **Simultaneous events:**
  - Write+pop at `fifo_level`=7 → level stays 7 and the head advances.
  - Write+pop at full → pop accepted, write dropped, `drop_cnt`+1, level 15.
  - `fifo_clear` with write+pop in the same cycle → level 0, `fifo_ovf` unchanged.
